// File: rtl/xor_decrypt_pkg.sv
// Shared definitions for the XOR crypt blocks: default geometry and FSM state encoding.
package xor_decrypt_pkg;

    localparam int unsigned DEF_MSG_SIZE = 64;
    localparam int unsigned DEF_KEY_SIZE = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DECRYPT = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_DONE    = 2'd3
    } crypt_state_t;

    function automatic int unsigned num_chunks(input int unsigned msg_size,
                                               input int unsigned key_size);
        return msg_size / key_size;
    endfunction

endpackage

// File: rtl/xor_decrypt_serializer.sv
// MSB-first serializer for the recovered plaintext: bit index, valid/ready handshake, last-bit flag.
module plaintext_serializer
    import xor_decrypt_pkg::*;
#(
    parameter  int unsigned MSG_SIZE = DEF_MSG_SIZE,
    localparam int unsigned BW       = $clog2(MSG_SIZE) + 1,
    localparam int unsigned IW       = $clog2(MSG_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                clear,
    input  logic                valid,
    input  logic                ready,
    input  logic [MSG_SIZE-1:0] plaintext,
    output logic                bit_out,
    output logic                xfer,
    output logic                last
);

    logic [BW-1:0] idx;
    logic [IW-1:0] sel;

    assign sel     = IW'(MSG_SIZE - 1) - idx[IW-1:0];
    assign bit_out = valid & plaintext[sel];
    assign xfer    = valid & ready & ena;
    assign last    = (idx == BW'(MSG_SIZE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (ena) begin
            if (clear) begin
                idx <= '0;
            end else if (xfer) begin
                idx <= idx + BW'(1);
            end
        end
    end

endmodule

// File: rtl/xor_decrypt.sv
// Receive-side XOR decryptor: latches ciphertext/key, XORs one key-wide chunk per enabled cycle,
// then streams the plaintext out MSB-first over a valid/ready bit interface.
module xor_decrypt
    import xor_decrypt_pkg::*;
#(
    parameter  int unsigned MSG_SIZE   = DEF_MSG_SIZE,
    parameter  int unsigned KEY_SIZE   = DEF_KEY_SIZE,
    localparam int unsigned NUM_CHUNKS = num_chunks(MSG_SIZE, KEY_SIZE),
    localparam int unsigned CW         = $clog2(NUM_CHUNKS) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                iStart,
    input  logic [MSG_SIZE-1:0] iCiphertext,
    input  logic [KEY_SIZE-1:0] iKey,
    input  logic                iBit_ready,
    output logic                oBusy,
    output logic                oDecryption_status,
    output logic [CW-1:0]       oChunk_counter,
    output logic [MSG_SIZE-1:0] oPlaintext,
    output logic                oBit,
    output logic                oBit_valid,
    output logic                oDone
);

    localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

    crypt_state_t        state;
    logic [MSG_SIZE-1:0] cipher_q;
    logic [KEY_SIZE-1:0] key_q;
    logic                start_acc;
    logic                bit_xfer;
    logic                bit_last;

    assign start_acc = (state == ST_IDLE) & iStart;

    plaintext_serializer #(
        .MSG_SIZE (MSG_SIZE)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .clear     (start_acc),
        .valid     (oBit_valid),
        .ready     (iBit_ready),
        .plaintext (oPlaintext),
        .bit_out   (oBit),
        .xfer      (bit_xfer),
        .last      (bit_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            cipher_q           <= '0;
            key_q              <= '0;
            oBusy              <= 1'b0;
            oDecryption_status <= 1'b0;
            oChunk_counter     <= '0;
            oPlaintext         <= '0;
            oBit_valid         <= 1'b0;
            oDone              <= 1'b0;
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        state              <= ST_DECRYPT;
                        cipher_q           <= iCiphertext;
                        key_q              <= iKey;
                        oPlaintext         <= '0;
                        oChunk_counter     <= '0;
                        oBusy              <= 1'b1;
                        oDecryption_status <= 1'b1;
                    end
                end
                ST_DECRYPT: begin
                    // Variable chunk part-select expressed as a decoded loop over fixed slices
                    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
                        if (oChunk_counter == CW'(i)) begin
                            oPlaintext[i*KEY_SIZE +: KEY_SIZE] <= cipher_q[i*KEY_SIZE +: KEY_SIZE] ^ key_q;
                        end
                    end
                    oChunk_counter <= oChunk_counter + CW'(1);
                    if (oChunk_counter == LAST_CHUNK) begin
                        state              <= ST_SHIFT;
                        oDecryption_status <= 1'b0;
                        oBit_valid         <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bit_xfer && bit_last) begin
                        state      <= ST_DONE;
                        oBit_valid <= 1'b0;
                        oDone      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    oDone <= 1'b0;
                    oBusy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_decrypt.sv
// Directed bench for xor_decrypt: vector table of full transactions plus freeze/reset/backpressure sequences.
module tb_xor_decrypt;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        iStart;
    logic [63:0] iCiphertext;
    logic [7:0]  iKey;
    logic        iBit_ready;
    logic        oBusy;
    logic        oDecryption_status;
    logic [3:0]  oChunk_counter;
    logic [63:0] oPlaintext;
    logic        oBit;
    logic        oBit_valid;
    logic        oDone;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] cipher;
        logic [7:0]  key;
        logic [63:0] plain;
    } vec_t;

    vec_t vecs [5];

    xor_decrypt #(
        .MSG_SIZE (64),
        .KEY_SIZE (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ena                (ena),
        .iStart             (iStart),
        .iCiphertext        (iCiphertext),
        .iKey               (iKey),
        .iBit_ready         (iBit_ready),
        .oBusy              (oBusy),
        .oDecryption_status (oDecryption_status),
        .oChunk_counter     (oChunk_counter),
        .oPlaintext         (oPlaintext),
        .oBit               (oBit),
        .oBit_valid         (oBit_valid),
        .oDone              (oDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [63:0] c, input logic [7:0] k);
        @(negedge clk);
        iStart      = 1'b1;
        iCiphertext = c;
        iKey        = k;
        @(negedge clk);
        iStart      = 1'b0;
    endtask

    task automatic wait_shift(output int cyc);
        cyc = 0;
        while (!oBit_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic collect(input bit rnd, output logic [63:0] bits, output int n,
                           output int drops, output int stab);
        int  cyc;
        bit  stalled;
        bit  r;
        logic prev_bit;
        bits = '0; n = 0; drops = 0; stab = 0; cyc = 0; stalled = 0; prev_bit = 1'b0;
        while (n < 64 && cyc < 2000) begin
            if (!oBit_valid) drops++;
            if (stalled && oBit !== prev_bit) stab++;
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            iBit_ready = r;
            if (oBit_valid && r) begin
                bits[63-n] = oBit;
                n++;
                stalled = 0;
            end else begin
                stalled  = 1;
                prev_bit = oBit;
            end
            @(negedge clk);
            cyc++;
        end
        iBit_ready = 1'b0;
    endtask

    task automatic finish_check(input logic [63:0] exp);
        check("done_pulse", 64'(oDone), 64'd1);
        check("valid_low_in_done", 64'(oBit_valid), 64'd0);
        @(negedge clk);
        check("done_cleared", 64'(oDone), 64'd0);
        check("idle_not_busy", 64'(oBusy), 64'd0);
        check("plain_hold", oPlaintext, exp);
        check("counter_hold", 64'(oChunk_counter), 64'd8);
    endtask

    task automatic run_vec(input logic [63:0] c, input logic [7:0] k, input logic [63:0] exp);
        int cyc, n, drops, stab;
        logic [63:0] bits;
        do_start(c, k);
        check("busy_decrypt", 64'({oBusy, oDecryption_status}), 64'd3);
        wait_shift(cyc);
        check("latency", 64'(cyc), 64'd8);
        check("plaintext", oPlaintext, exp);
        check("counter_end", 64'(oChunk_counter), 64'd8);
        check("status_shift", 64'({oBusy, oDecryption_status}), 64'd2);
        collect(1'b0, bits, n, drops, stab);
        check("serial_bits", bits, exp);
        finish_check(exp);
    endtask

    initial begin
        logic [63:0] bits, msg, pt_snap;
        logic [7:0]  rk;
        int          cyc, n, drops, stab, k;

        vecs[0] = '{64'h5B791F3DD3F197B5, 8'h5A, 64'h0123456789ABCDEF};
        vecs[1] = '{64'hDEADBEEFCAFEF00D, 8'h00, 64'hDEADBEEFCAFEF00D};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0000000000000000};
        vecs[3] = '{64'h0000000000000000, 8'hA5, 64'hA5A5A5A5A5A5A5A5};
        vecs[4] = '{64'h0011223344556677, 8'h0F, 64'h0F1E2D3C4B5A6978};

        rst = 1'b1; ena = 1'b1; iStart = 1'b1; iCiphertext = 64'h1234; iKey = 8'h55; iBit_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_flags", 64'({oBusy, oDecryption_status, oBit, oBit_valid, oDone}), 64'd0);
        check("reset_counter", 64'(oChunk_counter), 64'd0);
        check("reset_plain", oPlaintext, 64'd0);
        iStart = 1'b0;
        rst    = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i].cipher, vecs[i].key, vecs[i].plain);
        end

        // backpressure with random ready
        do_start(vecs[4].cipher, vecs[4].key);
        wait_shift(cyc);
        check("bp_latency", 64'(cyc), 64'd8);
        collect(1'b1, bits, n, drops, stab);
        check("bp_count", 64'(n), 64'd64);
        check("bp_bits", bits, vecs[4].plain);
        check("bp_valid_drops", 64'(drops), 64'd0);
        check("bp_stable", 64'(stab), 64'd0);
        finish_check(vecs[4].plain);

        // ena low for 3 cycles at chunk 4, then low in SHIFT and in DONE
        do_start(vecs[0].cipher, vecs[0].key);
        k = 0;
        while (oChunk_counter != 4'd4 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("freeze_reach", 64'(k), 64'd4);
        pt_snap = oPlaintext;
        check("freeze_partial", pt_snap, 64'h0000000089ABCDEF);
        ena = 1'b0;
        repeat (3) @(negedge clk);
        check("freeze_counter", 64'(oChunk_counter), 64'd4);
        check("freeze_plain", oPlaintext, pt_snap);
        check("freeze_status", 64'(oDecryption_status), 64'd1);
        ena = 1'b1;
        wait_shift(cyc);
        check("freeze_remaining", 64'(cyc), 64'd4);
        ena = 1'b0; iBit_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("freeze_shift_valid", 64'(oBit_valid), 64'd1);
        check("freeze_shift_bit", 64'(oBit), 64'(vecs[0].plain[63]));
        iBit_ready = 1'b0; ena = 1'b1;
        collect(1'b0, bits, n, drops, stab);
        check("freeze_bits", bits, vecs[0].plain);
        ena = 1'b0;
        repeat (2) @(negedge clk);
        check("freeze_done_held", 64'(oDone), 64'd1);
        ena = 1'b1;
        finish_check(vecs[0].plain);

        // reset mid-decrypt
        do_start(vecs[3].cipher, vecs[3].key);
        k = 0;
        while (oChunk_counter != 4'd4 && k < 100) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_flags", 64'({oBusy, oDecryption_status, oBit, oBit_valid, oDone}), 64'd0);
        check("midrst_counter", 64'(oChunk_counter), 64'd0);
        check("midrst_plain", oPlaintext, 64'd0);
        k = 0;
        repeat (4) begin
            @(negedge clk);
            if (oDone || oBusy) k++;
        end
        check("midrst_no_done", 64'(k), 64'd0);
        run_vec(vecs[1].cipher, vecs[1].key, vecs[1].plain);

        // start and input changes while busy are ignored
        do_start(vecs[0].cipher, vecs[0].key);
        iStart = 1'b1; iCiphertext = 64'hFEDCBA9876543210; iKey = 8'hC3;
        wait_shift(cyc);
        check("ign_latency", 64'(cyc), 64'd8);
        check("ign_plain", oPlaintext, vecs[0].plain);
        repeat (2) @(negedge clk);
        check("ign_shift_state", 64'({oBusy, oBit_valid, oChunk_counter}), 64'h38);
        iStart = 1'b0;
        collect(1'b0, bits, n, drops, stab);
        check("ign_bits", bits, vecs[0].plain);
        finish_check(vecs[0].plain);

        // round trip through an encrypt model
        msg = {$urandom, $urandom};
        rk  = 8'($urandom_range(1, 255));
        run_vec(msg ^ {8{rk}}, rk, msg);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
